// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart transmitter between NREQ byte requesters.
// Optional WR/BUSY watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned TIMEOUT_CYC = 200000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           baud_cfg,
    input  logic [NREQ-1:0]      req,
    input  logic [8*NREQ-1:0]    req_data,
    output logic [NREQ-1:0]      grant,
    output logic [NREQ-1:0]      done,
    output logic                 timeout_err,
    output logic                 Tx_EN,
    output logic                 Tx_WR,
    output logic [7:0]           Tx_DATA,
    output logic [2:0]           baud_select,
    input  logic                 Tx_BUSY
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        BUSY = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [PW-1:0]      ptr, ptr_nxt, gsel, gsel_nxt, ptr_after, pick_idx;
    logic               pick_hit;
    logic               busy_s;
    logic [NREQ-1:0]    grant_nxt, done_nxt;
    logic               en_nxt, wr_nxt;
    logic [7:0]         data_nxt;
    logic [2:0]         baud_nxt;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0]      tcnt, tcnt_nxt;
    logic               terr_nxt;
`else
    logic               unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC == 0);
    assign timeout_err    = 1'b0;
`endif

    function automatic int unsigned rr_idx(input logic [PW-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        return (s >= NREQ) ? s - NREQ : s;
    endfunction

    // First pending request at or above ptr, wrapping
    always_comb begin
        pick_hit = 1'b0;
        pick_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!pick_hit && req[PW'(rr_idx(ptr, i))]) begin
                pick_hit = 1'b1;
                pick_idx = PW'(rr_idx(ptr, i));
            end
        end
    end

    assign ptr_after = (gsel == PW'(NREQ - 1)) ? '0 : gsel + PW'(1);

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        gsel_nxt  = gsel;
        grant_nxt = grant;
        done_nxt  = '0;
        en_nxt    = Tx_EN;
        wr_nxt    = Tx_WR;
        data_nxt  = Tx_DATA;
        baud_nxt  = baud_select;
`ifdef UART_ARB_TIMEOUT_EN
        tcnt_nxt  = tcnt;
        terr_nxt  = 1'b0;
`endif
        case (state)
            IDLE: begin
                baud_nxt = baud_cfg;
                if (pick_hit) begin
                    state_nxt = WR;
                    gsel_nxt  = pick_idx;
                    grant_nxt = NREQ'(1) << pick_idx;
                    data_nxt  = req_data[{pick_idx, 3'b000} +: 8];
                    wr_nxt    = 1'b1;
                    en_nxt    = 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
                    tcnt_nxt  = '0;
`endif
                end
            end
            WR: begin
                if (busy_s) begin
                    wr_nxt    = 1'b0;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (!busy_s) begin
                    done_nxt  = grant;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                grant_nxt = '0;
                en_nxt    = 1'b0;
                ptr_nxt   = ptr_after;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
`ifdef UART_ARB_TIMEOUT_EN
        // Watchdog abort overrides normal WR/BUSY progress
        if (state == WR || state == BUSY) begin
            if (tcnt == CW'(TIMEOUT_CYC - 1)) begin
                state_nxt = IDLE;
                wr_nxt    = 1'b0;
                grant_nxt = '0;
                en_nxt    = 1'b0;
                done_nxt  = '0;
                terr_nxt  = 1'b1;
                ptr_nxt   = ptr_after;
            end else begin
                tcnt_nxt  = tcnt + CW'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            ptr         <= '0;
            gsel        <= '0;
            grant       <= '0;
            done        <= '0;
            Tx_EN       <= 1'b0;
            Tx_WR       <= 1'b0;
            Tx_DATA     <= '0;
            baud_select <= 3'b111;
            busy_s      <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            gsel        <= gsel_nxt;
            grant       <= grant_nxt;
            done        <= done_nxt;
            Tx_EN       <= en_nxt;
            Tx_WR       <= wr_nxt;
            Tx_DATA     <= data_nxt;
            baud_select <= baud_nxt;
            busy_s      <= Tx_BUSY;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcnt        <= '0;
            timeout_err <= 1'b0;
        end else begin
            tcnt        <= tcnt_nxt;
            timeout_err <= terr_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: transaction-rule model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uart_tx_arbiter;
    localparam int unsigned N  = 4;
    localparam int unsigned TO = 50;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [2:0]     baud_cfg = 3'd0;
    logic [N-1:0]   req = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   grant, done;
    logic           timeout_err, Tx_EN, Tx_WR;
    logic [7:0]     Tx_DATA;
    logic [2:0]     baud_select;
    logic           Tx_BUSY = 1'b0;

    uart_tx_arbiter #(.NREQ(N), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset), .baud_cfg(baud_cfg), .req(req), .req_data(req_data),
        .grant(grant), .done(done), .timeout_err(timeout_err), .Tx_EN(Tx_EN),
        .Tx_WR(Tx_WR), .Tx_DATA(Tx_DATA), .baud_select(baud_select), .Tx_BUSY(Tx_BUSY)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0, cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Uart stand-in: BUSY rises dly_cfg negedges after seeing Tx_WR, stays hold_cfg cycles
    int dly_cfg = 3, hold_cfg = 100, uphase = 0, ucnt = 0;
    bit stuck = 1'b0;
    always @(negedge clk) begin
        if (!reset || stuck) begin
            Tx_BUSY = 1'b0;
            uphase  = 0;
        end else begin
            case (uphase)
                0: if (Tx_WR) begin ucnt = dly_cfg; uphase = 1; end
                1: begin ucnt--; if (ucnt <= 0) begin Tx_BUSY = 1'b1; ucnt = hold_cfg; uphase = 2; end end
                2: begin ucnt--; if (ucnt <= 0) begin Tx_BUSY = 1'b0; uphase = 3; end end
                default: if (!Tx_WR) uphase = 0;
            endcase
        end
    end

    function automatic int pick(input logic [N-1:0] rq, input int p);
        for (int i = 0; i < int'(N); i++) begin
            if (rq[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    function automatic int idx_of(input logic [N-1:0] v);
        for (int i = 0; i < int'(N); i++) if (v[i]) return i;
        return -1;
    endfunction

    // Model: one transaction owner; Tx_WR until the filtered busy is seen high,
    // done on the first filtered-low cycle after that, release one cycle later.
    int         m_owner = -1, m_ptr = 0, m_tcnt = 0;
    bit         m_seen = 0, m_fin = 0, m_bs = 0, m_done = 0, m_terr = 0;
    logic [2:0] m_baud = 3'b111;
    logic [7:0] m_data = 8'h00;

    int         g_idx[$], g_cyc[$], d_idx[$], d_cyc[$], te_cyc[$];
    logic [7:0] g_dat[$];
    int         wr_cnt = 0;
    logic [N-1:0] prev_grant = '0;

    always @(posedge clk) begin : model
        logic [N-1:0]   rq, e_grant, e_done;
        logic [8*N-1:0] rd;
        logic [2:0]     bc;
        logic           bz;
        bit             old_bs, abort;
        int             g;
        rq = req; rd = req_data; bc = baud_cfg; bz = Tx_BUSY;
        cyc++;
        if (!reset) begin
            m_owner = -1; m_ptr = 0; m_tcnt = 0; m_seen = 0; m_fin = 0;
            m_bs = 0; m_done = 0; m_terr = 0; m_baud = 3'b111; m_data = 8'h00;
        end else begin
            old_bs = m_bs; m_done = 0; m_terr = 0; abort = 0;
            if (m_owner < 0) begin
                m_baud = bc;
                g = pick(rq, m_ptr);
                if (g >= 0) begin
                    m_owner = g; m_data = rd[8*g +: 8];
                    m_seen = 0; m_fin = 0; m_tcnt = 0;
                end
            end else if (m_fin) begin
                m_ptr = (m_owner + 1) % N;
                m_owner = -1;
            end else begin
`ifdef UART_ARB_TIMEOUT_EN
                if (m_tcnt == int'(TO) - 1) abort = 1;
                else m_tcnt++;
`endif
                if (abort) begin
                    m_terr = 1; m_ptr = (m_owner + 1) % N; m_owner = -1;
                end else if (!m_seen) begin
                    if (old_bs) m_seen = 1;
                end else if (!old_bs) begin
                    m_done = 1; m_fin = 1;
                end
            end
            m_bs = bz;
        end
        e_grant = (m_owner >= 0) ? N'(1) << m_owner : '0;
        e_done  = (m_done && m_owner >= 0) ? N'(1) << m_owner : '0;
        #1;
        chk("grant",       32'(grant),       32'(e_grant));
        chk("done",        32'(done),        32'(e_done));
        chk("Tx_EN",       32'(Tx_EN),       32'(m_owner >= 0));
        chk("Tx_WR",       32'(Tx_WR),       32'(m_owner >= 0 && !m_seen));
        chk("Tx_DATA",     32'(Tx_DATA),     32'(m_data));
        chk("baud_select", 32'(baud_select), 32'(m_baud));
        chk("timeout_err", 32'(timeout_err), 32'(m_terr));
        if (grant != 0 && prev_grant == 0) begin
            g_idx.push_back(idx_of(grant)); g_dat.push_back(Tx_DATA); g_cyc.push_back(cyc);
        end
        if (done != 0) begin d_idx.push_back(idx_of(done)); d_cyc.push_back(cyc); end
        if (timeout_err) te_cyc.push_back(cyc);
        if (Tx_WR) wr_cnt++;
        prev_grant = grant;
    end

    task automatic clear_log();
        g_idx.delete(); g_dat.delete(); g_cyc.delete();
        d_idx.delete(); d_cyc.delete(); te_cyc.delete(); wr_cnt = 0;
    endtask

    task automatic pulse_reset();
        @(negedge clk) reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        clear_log();
    endtask

    task automatic wait_grants(input int n, input int budget);
        int k = 0;
        while (g_idx.size() < n && k < budget) begin @(negedge clk); k++; end
        chk("grant_wait", 32'(g_idx.size()), 32'(n));
    endtask

    task automatic wait_dones(input int n, input int budget);
        int k = 0;
        while (d_idx.size() < n && k < budget) begin @(negedge clk); k++; end
        chk("done_wait", 32'(d_idx.size()), 32'(n));
    endtask

    task automatic wait_wr_low(input int budget);
        int k = 0;
        while (Tx_WR && k < budget) begin @(negedge clk); k++; end
        chk("wr_drop", 32'(Tx_WR), 32'(0));
    endtask

    initial begin
        logic [7:0] exp_dat [5];
        int         exp_idx [5];
        exp_dat = '{8'hAA, 8'h55, 8'hCC, 8'h89, 8'hAA};
        exp_idx = '{0, 1, 2, 3, 0};

        // Reset values
        repeat (10) @(negedge clk);
        chk("rst_grant", 32'(grant), 32'(0));
        chk("rst_wr",    32'(Tx_WR), 32'(0));
        chk("rst_en",    32'(Tx_EN), 32'(0));
        chk("rst_data",  32'(Tx_DATA), 32'(0));
        chk("rst_baud",  32'(baud_select), 32'(3'b111));

        // Single byte
        reset = 1'b1; clear_log();
        req_data[7:0] = 8'hAA; dly_cfg = 3; hold_cfg = 100;
        @(negedge clk) req = 4'b0001;
        wait_grants(1, 10);
        req = 4'b0000;
        wait_dones(1, 300);
        repeat (5) @(negedge clk);
        if (g_idx.size() >= 1 && d_idx.size() >= 1) begin
            chk("t2_gidx", 32'(g_idx[0]), 32'(0));
            chk("t2_data", 32'(g_dat[0]), 32'(8'hAA));
            chk("t2_lat",  32'(d_cyc[0] - g_cyc[0]), 32'(105));
        end
        chk("t2_wrcnt", 32'(wr_cnt), 32'(5));
        chk("t2_ndone", 32'(d_idx.size()), 32'(1));

        // Round-robin over four held requests
        pulse_reset();
        req_data = {8'h89, 8'hCC, 8'h55, 8'hAA}; dly_cfg = 2; hold_cfg = 3;
        @(negedge clk) req = 4'b1111;
        wait_grants(5, 200);
        req = 4'b0000;
        wait_dones(5, 200);
        for (int i = 0; i < 5; i++) begin
            if (g_idx.size() > i && d_idx.size() > i) begin
                chk("t3_gidx", 32'(g_idx[i]), 32'(exp_idx[i]));
                chk("t3_data", 32'(g_dat[i]), 32'(exp_dat[i]));
                chk("t3_didx", 32'(d_idx[i]), 32'(exp_idx[i]));
            end
        end

        // Late drop of requester 2 while requester 0 is busy
        pulse_reset();
        hold_cfg = 6;
        @(negedge clk) req = 4'b0101;
        wait_grants(1, 10);
        wait_wr_low(50);
        req = 4'b0001;
        wait_grants(2, 100);
        req = 4'b0000;
        wait_dones(2, 100);
        repeat (10) @(negedge clk);
        if (g_idx.size() >= 2) chk("t4_regrant", 32'(g_idx[1]), 32'(0));
        chk("t4_ngrant", 32'(g_idx.size()), 32'(2));

        // Baud change during BUSY, then reset mid-BUSY
        pulse_reset();
        baud_cfg = 3'b101; hold_cfg = 20;
        repeat (3) @(negedge clk);
        chk("t5_baud_idle", 32'(baud_select), 32'(3'b101));
        req = 4'b0001;
        wait_grants(1, 10);
        req = 4'b0000;
        wait_wr_low(50);
        baud_cfg = 3'b010;
        repeat (3) @(negedge clk);
        chk("t5_baud_hold", 32'(baud_select), 32'(3'b101));
        wait_dones(1, 100);
        chk("t5_baud_done", 32'(baud_select), 32'(3'b101));
        repeat (2) @(negedge clk);
        chk("t5_baud_new", 32'(baud_select), 32'(3'b010));
        clear_log();
        req = 4'b0001;
        wait_grants(1, 10);
        req = 4'b0000;
        wait_wr_low(50);
        reset = 1'b0;
        #1;
        chk("t5_rst_grant", 32'(grant), 32'(0));
        chk("t5_rst_wr",    32'(Tx_WR), 32'(0));
        chk("t5_rst_en",    32'(Tx_EN), 32'(0));
        @(negedge clk) reset = 1'b1;
        repeat (30) @(negedge clk);
        chk("t5_no_done", 32'(d_idx.size()), 32'(0));

        // Stuck uart busy
        pulse_reset();
        stuck = 1'b1;
        @(negedge clk) req = 4'b0011;
        wait_grants(1, 10);
`ifdef UART_ARB_TIMEOUT_EN
        begin
            int k = 0;
            while (te_cyc.size() < 1 && k < 80) begin @(negedge clk); k++; end
        end
        chk("t6_nterr", 32'(te_cyc.size()), 32'(1));
        if (te_cyc.size() >= 1) chk("t6_tlat", 32'(te_cyc[0] - g_cyc[0]), 32'(TO));
        chk("t6_no_done", 32'(d_idx.size()), 32'(0));
        wait_grants(2, 10);
        if (g_idx.size() >= 2) chk("t6_next", 32'(g_idx[1]), 32'(1));
        req = 4'b0000;
        stuck = 1'b0;
        wait_dones(1, 100);
`else
        repeat (60) @(negedge clk);
        chk("t6_wr_held", 32'(Tx_WR), 32'(1));
        chk("t6_grant",   32'(grant), 32'(4'b0001));
        chk("t6_no_terr", 32'(te_cyc.size()), 32'(0));
        req = 4'b0000;
        stuck = 1'b0;
        wait_dones(1, 100);
`endif

        // Randomized traffic
        pulse_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            req_data = 32'($urandom);
            if ($urandom_range(0, 3) == 0) req = N'($urandom);
            if ($urandom_range(0, 7) == 0) baud_cfg = 3'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                dly_cfg  = $urandom_range(1, 4);
                hold_cfg = $urandom_range(1, 6);
            end
            reset = ($urandom_range(0, 699) != 0);
        end
        @(negedge clk) reset = 1'b1;
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
